// File: rtl/wakeup_select_matrix.sv
// -----------------------------------------------------------------------------
// wakeup_select_matrix
//   Dependency-matrix scheduler. Each entry holds an instruction waiting on
//   a set of producer entries (one bit per column). When a producer's latency
//   countdown expires it broadcasts on wakeup_vec for one cycle, its column is
//   cleared in every row, and the entry is returned to the free pool.
//
// Ports
//   clk, rst          : clock, asynchronous active-low reset
//   disp_valid/ready  : dispatch handshake; disp_row = lowest free entry
//   disp_dep          : producer entries the new instruction waits on
//   disp_latency      : execution latency of the new instruction (0 acts as 1)
//   issue_valid/ready : issue handshake; issue_row = lowest ready entry
//   wakeup_vec        : per-entry result broadcast this cycle
//   flush             : synchronous discard of every entry
//   free_count        : registered number of free entries
// -----------------------------------------------------------------------------
module wakeup_select_matrix #(
   parameter int NUM_ROWS = 8,
   parameter int LAT_W    = 4
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        disp_valid,
   output logic                        disp_ready,
   input  logic [NUM_ROWS-1:0]         disp_dep,
   input  logic [LAT_W-1:0]            disp_latency,
   output logic [$clog2(NUM_ROWS)-1:0] disp_row,
   output logic                        issue_valid,
   output logic [$clog2(NUM_ROWS)-1:0] issue_row,
   input  logic                        issue_ready,
   output logic [NUM_ROWS-1:0]         wakeup_vec,
   input  logic                        flush,
   output logic [$clog2(NUM_ROWS):0]   free_count
);

   localparam int IDX_W = $clog2(NUM_ROWS);
   localparam int CNT_W = IDX_W + 1;

   typedef enum logic [1:0] {ST_FREE, ST_WAIT, ST_ISSUED} ent_state_e;

   ent_state_e                        st_q [NUM_ROWS];
   logic [NUM_ROWS-1:0][NUM_ROWS-1:0] dep_q;
   logic [NUM_ROWS-1:0][LAT_W-1:0]    lat_q;
   logic [NUM_ROWS-1:0][LAT_W-1:0]    cnt_q;
   logic [CNT_W-1:0]                  free_cnt_q;

   logic [NUM_ROWS-1:0] free_mask;
   logic [NUM_ROWS-1:0] ready;
   logic [CNT_W-1:0]    wake_cnt;
   logic                disp_fire;
   logic                issue_fire;

   genvar j;
   for (j = 0; j < NUM_ROWS; j++) begin : g_flags
      assign free_mask[j]  = (st_q[j] == ST_FREE);
      // Broadcast is suppressed during flush so nothing observes a dying entry.
      assign wakeup_vec[j] = !flush && (st_q[j] == ST_ISSUED) && (cnt_q[j] == '0);
      // Producers broadcasting this cycle already count as satisfied, which
      // lets a latency-L dependent issue exactly L cycles after its producer.
      assign ready[j]      = (st_q[j] == ST_WAIT) && ((dep_q[j] & ~wakeup_vec) == '0);
   end

   // Lowest-index pick for allocation and issue; popcount of broadcasts.
   always_comb begin
      disp_row  = '0;
      issue_row = '0;
      wake_cnt  = '0;
      for (int i = NUM_ROWS - 1; i >= 0; i--) begin
         if (free_mask[i]) disp_row  = IDX_W'(i);
         if (ready[i])     issue_row = IDX_W'(i);
      end
      for (int i = 0; i < NUM_ROWS; i++)
         wake_cnt = wake_cnt + CNT_W'(wakeup_vec[i]);
   end

   assign issue_valid = |ready;
   assign disp_ready  = (free_cnt_q != '0);
   assign free_count  = free_cnt_q;
   assign disp_fire   = disp_valid && disp_ready && !flush;
   assign issue_fire  = issue_valid && issue_ready && !flush;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         free_cnt_q <= CNT_W'(NUM_ROWS);
         for (int i = 0; i < NUM_ROWS; i++) begin
            st_q[i]  <= ST_FREE;
            dep_q[i] <= '0;
            lat_q[i] <= '0;
            cnt_q[i] <= '0;
         end
      end else if (flush) begin
         free_cnt_q <= CNT_W'(NUM_ROWS);
         for (int i = 0; i < NUM_ROWS; i++) begin
            st_q[i]  <= ST_FREE;
            dep_q[i] <= '0;
            lat_q[i] <= '0;
            cnt_q[i] <= '0;
         end
      end else begin
         // Entries freed this edge are not in free_mask until the next cycle,
         // so the counter and the allocator always agree.
         free_cnt_q <= free_cnt_q + wake_cnt - CNT_W'(disp_fire);
         for (int i = 0; i < NUM_ROWS; i++) begin
            dep_q[i] <= dep_q[i] & ~wakeup_vec;
            unique case (st_q[i])
               ST_FREE: begin
                  if (disp_fire && (disp_row == IDX_W'(i))) begin
                     st_q[i]  <= ST_WAIT;
                     // Deps on free or currently broadcasting entries are
                     // already satisfied; never depend on yourself.
                     dep_q[i] <= disp_dep & ~free_mask & ~wakeup_vec
                                 & ~(NUM_ROWS'(1) << i);
                     lat_q[i] <= disp_latency;
                     cnt_q[i] <= '0;
                  end
               end
               ST_WAIT: begin
                  if (issue_fire && (issue_row == IDX_W'(i))) begin
                     st_q[i]  <= ST_ISSUED;
                     cnt_q[i] <= (lat_q[i] == '0) ? '0 : lat_q[i] - 1'b1;
                  end
               end
               ST_ISSUED: begin
                  if (cnt_q[i] != '0) begin
                     cnt_q[i] <= cnt_q[i] - 1'b1;
                  end else begin
                     st_q[i]  <= ST_FREE;
                     dep_q[i] <= '0;
                  end
               end
               default: st_q[i] <= ST_FREE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_wakeup_select_matrix.sv
// -----------------------------------------------------------------------------
// tb_wakeup_select_matrix
//   Scoreboard bench. The driver applies inputs on the falling edge, advances
//   a timestamp-based reference model by one cycle and pushes the outputs the
//   model expects after the next rising edge. A monitor pops and compares one
//   snapshot per rising edge.
// -----------------------------------------------------------------------------
module tb_wakeup_select_matrix;

   localparam int N  = 8;
   localparam int LW = 4;
   localparam int M_FREE = 0;
   localparam int M_WAIT = 1;
   localparam int M_ISS  = 2;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          disp_valid = 1'b0;
   logic          issue_ready = 1'b0;
   logic          flush = 1'b0;
   logic [N-1:0]  disp_dep = '0;
   logic [LW-1:0] disp_latency = '0;
   logic          disp_ready;
   logic          issue_valid;
   logic [2:0]    disp_row;
   logic [2:0]    issue_row;
   logic [N-1:0]  wakeup_vec;
   logic [3:0]    free_count;

   wakeup_select_matrix #(.NUM_ROWS(N), .LAT_W(LW)) dut (
      .clk          (clk),
      .rst          (rst),
      .disp_valid   (disp_valid),
      .disp_ready   (disp_ready),
      .disp_dep     (disp_dep),
      .disp_latency (disp_latency),
      .disp_row     (disp_row),
      .issue_valid  (issue_valid),
      .issue_row    (issue_row),
      .issue_ready  (issue_ready),
      .wakeup_vec   (wakeup_vec),
      .flush        (flush),
      .free_count   (free_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit           dr;
      int           drow;
      bit           iv;
      int           irow;
      logic [N-1:0] wk;
      int           fc;
   } exp_t;

   exp_t exp_q[$];
   int   n_chk = 0;
   int   n_err = 0;

   // Reference model: state per entry, the set of producers still pending,
   // and the absolute cycle number at which an issued entry broadcasts.
   int           m_st   [N];
   logic [N-1:0] m_dep  [N];
   int           m_lat  [N];
   int           m_wake [N];
   int           cyc = 0;

   task automatic chk(input string nm, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [N-1:0] m_wakes();
      logic [N-1:0] r = '0;
      for (int k = 0; k < N; k++) r[k] = (m_st[k] == M_ISS) && (m_wake[k] == cyc);
      return r;
   endfunction

   function automatic logic [N-1:0] m_frees();
      logic [N-1:0] r = '0;
      for (int k = 0; k < N; k++) r[k] = (m_st[k] == M_FREE);
      return r;
   endfunction

   function automatic logic [N-1:0] m_readys(input logic [N-1:0] wk);
      logic [N-1:0] r = '0;
      for (int k = 0; k < N; k++) r[k] = (m_st[k] == M_WAIT) && ((m_dep[k] & ~wk) == '0);
      return r;
   endfunction

   function automatic int lowest(input logic [N-1:0] v);
      for (int k = 0; k < N; k++) if (v[k]) return k;
      return 0;
   endfunction

   function automatic int popc(input logic [N-1:0] v);
      int c = 0;
      for (int k = 0; k < N; k++) c += int'(v[k]);
      return c;
   endfunction

   task automatic model_reset();
      for (int k = 0; k < N; k++) begin
         m_st[k] = M_FREE; m_dep[k] = '0; m_lat[k] = 0; m_wake[k] = 0;
      end
   endtask

   function automatic exp_t snapshot();
      exp_t e;
      logic [N-1:0] wk = m_wakes();
      logic [N-1:0] fr = m_frees();
      logic [N-1:0] rd = m_readys(wk);
      e.dr = (fr != '0); e.drow = lowest(fr);
      e.iv = (rd != '0); e.irow = lowest(rd);
      e.wk = wk;         e.fc   = popc(fr);
      return e;
   endfunction

   // One clock cycle: drive inputs, advance the model across the coming edge,
   // queue the expected post-edge outputs, then wait for the next falling edge.
   task automatic drive(input bit dv, input logic [N-1:0] dep, input int lat,
                        input bit ir, input bit fl);
      logic [N-1:0] wk, fr, rd;
      int dr, irw;
      rst = 1'b1; disp_valid = dv; disp_dep = dep;
      disp_latency = LW'(lat); issue_ready = ir; flush = fl;
      if (fl) begin
         model_reset();
      end else begin
         wk = m_wakes(); fr = m_frees(); rd = m_readys(wk);
         dr = lowest(fr); irw = lowest(rd);
         if (ir && rd != '0) begin
            m_st[irw]   = M_ISS;
            m_wake[irw] = cyc + ((m_lat[irw] < 1) ? 1 : m_lat[irw]);
         end
         for (int k = 0; k < N; k++) if (wk[k]) begin
            m_st[k] = M_FREE;
            for (int q = 0; q < N; q++) m_dep[q][k] = 1'b0;
         end
         if (dv && fr != '0) begin
            m_st[dr]      = M_WAIT;
            m_dep[dr]     = dep & ~fr & ~wk;
            m_dep[dr][dr] = 1'b0;
            m_lat[dr]     = lat & 15;
         end
      end
      cyc++;
      exp_q.push_back(snapshot());
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) drive(1'b0, '0, 0, 1'b1, 1'b0);
   endtask

   task automatic chk_reset_vals(input string pfx);
      chk({pfx, "_disp_ready"},  int'(disp_ready), 1);
      chk({pfx, "_disp_row"},    int'(disp_row), 0);
      chk({pfx, "_issue_valid"}, int'(issue_valid), 0);
      chk({pfx, "_wakeup_vec"},  int'(wakeup_vec), 0);
      chk({pfx, "_free_count"},  int'(free_count), N);
   endtask

   // Asynchronous reset between edges; outputs must settle without a clock.
   task automatic do_reset();
      #2 rst = 1'b0;
      #1 chk_reset_vals("async_rst");
      model_reset();
      @(negedge clk);
   endtask

   initial begin : mon
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("disp_ready", int'(disp_ready), int'(e.dr));
            if (e.dr) chk("disp_row", int'(disp_row), e.drow);
            chk("free_count", int'(free_count), e.fc);
            chk("issue_valid", int'(issue_valid), int'(e.iv));
            if (e.iv) chk("issue_row", int'(issue_row), e.irow);
            chk("wakeup_vec", int'(wakeup_vec), int'(e.wk));
         end
      end
   end

   initial begin : drv
      model_reset();
      @(negedge clk);
      chk_reset_vals("por");

      // Single L=1 producer: dispatch, issue, broadcast, free.
      drive(1'b1, '0, 1, 1'b0, 1'b0);
      drive(1'b0, '0, 0, 1'b1, 1'b0);
      idle(2);

      // L=3 producer with dependent B; B must wait exactly 3 cycles.
      drive(1'b1, '0, 3, 1'b0, 1'b0);
      drive(1'b1, 8'h01, 1, 1'b1, 1'b0);
      idle(6);

      // Fill every entry, ninth dispatch refused, then drain in index order.
      for (int k = 0; k < N + 1; k++) drive(1'b1, '0, 1, 1'b0, 1'b0);
      idle(12);

      // Dispatch during producer's broadcast cycle, plus a dep on a free entry.
      drive(1'b1, '0, 2, 1'b0, 1'b0);
      drive(1'b0, '0, 0, 1'b1, 1'b0);
      drive(1'b0, '0, 0, 1'b0, 1'b0);
      drive(1'b1, 8'h81, 1, 1'b0, 1'b0);
      idle(4);

      // Two producers broadcasting in the same cycle, shared dependent.
      drive(1'b1, '0, 3, 1'b0, 1'b0);
      drive(1'b1, '0, 1, 1'b0, 1'b0);
      drive(1'b1, 8'h03, 1, 1'b1, 1'b0);
      drive(1'b0, '0, 0, 1'b0, 1'b0);
      drive(1'b0, '0, 0, 1'b1, 1'b0);
      idle(5);

      // Flush with five live entries, one of them issued.
      for (int k = 0; k < 5; k++) drive(1'b1, '0, 4, (k == 4), 1'b0);
      drive(1'b1, '0, 1, 1'b1, 1'b1);
      idle(3);

      // Reset in the middle of a long countdown; nothing may wake afterwards.
      drive(1'b1, '0, 9, 1'b0, 1'b0);
      drive(1'b0, '0, 0, 1'b1, 1'b0);
      idle(3);
      do_reset();
      idle(12);

      // Randomized traffic with bursts of back-pressure and rare flushes.
      for (int i = 0; i < 600; i++) begin
         if (i == 300) do_reset();
         drive(($urandom % 4) != 0, N'($urandom & $urandom), int'($urandom % 6),
               (i % 80 < 20) ? 1'b0 : (($urandom % 3) != 0),
               ($urandom % 60) == 0);
      end
      idle(20);

      chk("scoreboard_empty", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule

// File: doc/wakeup_select_matrix.md
WAKEUP_SELECT_MATRIX -- requirements
Module: wakeup_select_matrix

Interface
REQ-001 SHALL have parameter NUM_ROWS, default 8: number of scheduler entries (power of 2, 2..32).
REQ-002 SHALL have parameter LAT_W, default 4: width of per-entry execution-latency field.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port disp_valid  input  1  dispatch request.
REQ-006 SHALL have port disp_ready  output  1  at least one entry free.
REQ-007 SHALL have port disp_dep  input  NUM_ROWS  bit j set = new instruction waits on entry j.
REQ-008 SHALL have port disp_latency  input  LAT_W  producer latency of new instruction, in cycles.
REQ-009 SHALL have port disp_row  output  $clog2(NUM_ROWS)  index allocated on dispatch handshake.
REQ-010 SHALL have port issue_valid  output  1  some entry is ready and unissued.
REQ-011 SHALL have port issue_row  output  $clog2(NUM_ROWS)  selected entry index.
REQ-012 SHALL have port issue_ready  input  1  functional unit accepts the selected entry.
REQ-013 SHALL have port wakeup_vec  output  NUM_ROWS  bit j = entry j broadcasts its result this cycle.
REQ-014 SHALL have port flush  input  1  synchronous discard of all entries.
REQ-015 SHALL have port free_count  output  $clog2(NUM_ROWS)+1  number of free entries.

Function
REQ-016 Each entry SHALL hold state FREE, WAIT, ISSUED, plus a NUM_ROWS-bit dependency row, a LAT_W latency field and a LAT_W countdown.
REQ-017 disp_ready SHALL equal (free_count != 0); disp_row SHALL be the lowest-index FREE entry in the registered free mask.
REQ-018 On disp_valid && disp_ready: entry disp_row -> WAIT; row <= disp_dep masked by (non-FREE entries) & ~wakeup_vec & ~(1<<disp_row); latency stored; disp_valid while !disp_ready SHALL be ignored.
REQ-019 Entry ready (combinational) SHALL be: state WAIT && (row & ~wakeup_vec) == 0.
REQ-020 issue_valid SHALL be OR of ready entries; issue_row SHALL be the lowest-index ready entry; issue_row is don't-care when issue_valid is 0.
REQ-021 On issue_valid && issue_ready: entry issue_row -> ISSUED, countdown <= max(latency,1) - 1; without issue_ready the selection SHALL hold or change only as readiness changes, never lose an entry.
REQ-022 An ISSUED entry with countdown != 0 SHALL decrement by 1 per cycle; with countdown == 0 it SHALL assert wakeup_vec[j] for exactly one cycle.
REQ-023 At the edge ending a wakeup cycle, column j SHALL be cleared in every row and entry j -> FREE.
REQ-024 Latency L (L>=1) SHALL let a dependent issue exactly L cycles after its producer's issue handshake (L=0 treated as 1).
REQ-025 An entry freed in cycle T SHALL not be allocatable before cycle T+1.
REQ-026 Multiple wakeup_vec bits MAY be set in one cycle; all corresponding columns SHALL clear together.
REQ-027 free_count SHALL be registered, updated by +frees -allocations each cycle, never exceeding NUM_ROWS or underflowing.
REQ-028 flush SHALL have priority: all entries -> FREE, rows and countdowns cleared, free_count <= NUM_ROWS, concurrent dispatch/issue ignored, wakeup_vec forced 0 during flush cycle.

Reset
REQ-029 While rst == 0 all entries SHALL be FREE, all rows/countdowns 0, free_count = NUM_ROWS, disp_ready = 1, disp_row = 0, issue_valid = 0, wakeup_vec = 0.
REQ-030 Reset assertion mid-operation SHALL immediately (asynchronously) return all state to REQ-029 values; first dispatch accepted on the first rising edge after deassertion.

Verification
REQ-031 Reset, dispatch A(dep=0,L=1) -> disp_row=0, issue_valid next cycle, issue_row=0; with issue_ready=1 wakeup_vec=0x01 one cycle later, free_count back to 8.
REQ-032 A(L=3) issued at edge T, B dispatched with dep=0x01 -> B ready/issued exactly 3 cycles after T; not earlier with issue_ready held 1.
REQ-033 Fill 8 entries with dep=0 and issue_ready=0 -> free_count=0, disp_ready=0, 9th disp_valid ignored; issue_ready=1 -> issue_row 0,1,2... in order.
REQ-034 Dispatch C with dep on entry whose wakeup_vec bit is high that cycle -> C's row bit clear, C ready next cycle; dep on FREE entry -> ignored.
REQ-035 Two entries issued with latencies giving same wakeup cycle -> wakeup_vec has both bits; shared dependent becomes ready next cycle; flush with 5 live entries -> free_count=8, issue_valid=0, no wakeup.
REQ-036 rst pulsed low mid-countdown -> outputs at REQ-029 values without clock edge, no stale wakeup after release.
